// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Optional MULDIV_FAST_SPECIAL_EN: zero/overflow operands bypass CALC and finish from PREP.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | operand magnitudes, sign flags, clear accumulator
// CALC  | one shift-add / restoring-divide step per cycle, XLEN steps
// FIXUP | sign correction and result select
// DONE  | done pulse, result valid
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_t;
  state_t state, state_nx;

  logic [2:0]        f3;
  logic [XLEN-1:0]   a_q, b_q, mag_a, mag_b, sh;
  logic              neg_q, neg_r;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              is_div, sgn_a, sgn_b, div0, ovf, mul0, special, last;
  logic [XLEN-1:0]   mag_a_w, mag_b_w, special_val, fix_val;
  logic [XLEN:0]     mul_sum, rem_sh, trial;
  logic [XLEN-1:0]   div_rem;
  logic              div_qbit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign is_div  = f3[2];
  assign sgn_a   = a_q[XLEN-1] & ((f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110));
  assign sgn_b   = b_q[XLEN-1] & ((f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110));
  assign mag_a_w = sgn_a ? -a_q : a_q;
  assign mag_b_w = sgn_b ? -b_q : b_q;

  assign div0    = is_div & (b_q == '0);
  assign ovf     = is_div & ~f3[0] & (a_q == MIN_NEG) & (b_q == '1);
  assign mul0    = ~is_div & ((a_q == '0) | (b_q == '0));
  assign special = div0 | ovf | mul0;
  assign last    = (cnt == CW'(XLEN-1));

  // RISC-V defined results; a zero multiply operand simply yields zero
  always_comb begin
    special_val = '0;
    if (div0)     special_val = f3[1] ? a_q : '1;
    else if (ovf) special_val = f3[1] ? '0  : MIN_NEG;
  end

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (sh[0] ? {1'b0, mag_a} : '0);
  assign rem_sh   = {acc[2*XLEN-1:XLEN], sh[XLEN-1]};
  assign trial    = rem_sh - {1'b0, mag_b};
  assign div_qbit = ~trial[XLEN];
  assign div_rem  = div_qbit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];

  assign prod  = neg_q ? -acc : acc;
  assign quo_s = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_s = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    if (special)         fix_val = special_val;
    else if (is_div)     fix_val = f3[1] ? rem_s : quo_s;
    else if (f3 == 3'b0) fix_val = prod[XLEN-1:0];
    else                 fix_val = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && !flush) state_nx = S_PREP;
      S_PREP: begin
        if (flush) state_nx = S_IDLE;
        else begin
`ifdef MULDIV_FAST_SPECIAL_EN
          state_nx = special ? S_DONE : S_CALC;
`else
          state_nx = S_CALC;
`endif
        end
      end
      S_CALC:  if (flush) state_nx = S_IDLE; else if (last) state_nx = S_FIXUP;
      S_FIXUP: state_nx = flush ? S_IDLE : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      sh     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && !flush) begin
          f3  <= funct3;
          a_q <= op_a;
          b_q <= op_b;
        end
        S_PREP: begin
          mag_a <= mag_a_w;
          mag_b <= mag_b_w;
          neg_q <= sgn_a ^ sgn_b;
          neg_r <= sgn_a;
          acc   <= '0;
          cnt   <= '0;
          sh    <= is_div ? mag_a_w : mag_b_w;
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          // multiply shifts the product right; divide shifts the remainder/quotient left
          if (is_div) begin
            acc <= {div_rem, acc[XLEN-2:0], div_qbit};
            sh  <= {sh[XLEN-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
            sh  <= {1'b0, sh[XLEN-1:1]};
          end
        end
        default: ;
      endcase
      if (state == S_FIXUP && !flush)                 result <= fix_val;
      else if (state == S_PREP && state_nx == S_DONE) result <= special_val;
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign stall_req = ((state == S_IDLE) & start & ~flush) | (state == S_PREP) |
                     (state == S_CALC) | (state == S_FIXUP);

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage. Each operation takes multiple cycles. The unit latches its operands on `start`, runs a fixed-iteration shift-add multiply or restoring divide, applies sign fix-up, and returns the result with a one-cycle `done` pulse. While an operation is in flight it raises `stall_req` to the hazard unit so the pipeline freezes. Decode steers R-type funct7=0000001 instructions here instead of to the ALU.

## Interface
- `XLEN`, default 32, operand/result width; must be even and ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; accepted only in IDLE with `flush`=0.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value / dividend.
- `op_b`  in  XLEN  rs2 value / divisor.
- `flush`  in  1  synchronous abort (branch mispredict / trap).
- `busy`  out  1  state ≠ IDLE.
- `stall_req`  out  1  pipeline hold request.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  last completed result; held until the next completion.

## Operation
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE→PREP when `start` and not `flush`.
  - Latch `funct3`, `op_a` and `op_b`.
  - Input changes after acceptance are ignored.
- PREP:
  - Compute operand magnitudes. Signed: a for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
  - Record the negate flags: quotient/product sign = sa^sb; remainder sign = sa.
  - Clear the 2·XLEN accumulator and the iteration counter. PREP→CALC.
- CALC: one iteration per cycle, exactly XLEN cycles. Counter runs 0..XLEN-1; on XLEN-1, go to FIXUP.
  - Multiply: shift-add on magnitudes into a 2·XLEN product.
  - Divide: restoring; shift the remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit if non-negative.
- FIXUP: negate per the flags, then select the result. FIXUP→DONE.
  - MUL: low half. MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- DONE: `done`=1, `result` updated on this state's entry edge. DONE→IDLE.
- Special cases (RISC-V defined, no trap):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1); remainder = 0.
- `flush` in any non-IDLE state: next edge goes to IDLE, no `done`, `result` unchanged. `flush` in DONE is ignored: the result completes.
- `start` outside IDLE is ignored, with no queueing.
- `stall_req` = (IDLE & `start` & !`flush`) | PREP | CALC | FIXUP.
  - It is low in DONE, so the pipeline advances and captures `result` in the same cycle.
- Reset: state IDLE, counter 0, accumulator 0, `result` 0, `done` 0, `busy` 0, `stall_req` 0. An assertion mid-operation discards the operation.

## Timing
- Cycle 0: `start` is sampled in IDLE.
- Cycle 1: PREP.
- Cycles 2..XLEN+1: CALC.
- Cycle XLEN+2: FIXUP.
- Cycle XLEN+3: DONE, `done`=1. This is cycle 35 for XLEN=32.
- Cycle XLEN+4: IDLE. The earliest new `start` is accepted here.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `done` is never high for two consecutive cycles.

## Configuration
- `MULDIV_FAST_SPECIAL_EN` defined:
  - In PREP, divisor 0, signed overflow, or either multiply operand 0 goes straight to DONE with the special result.
  - `done` is then at cycle 2.
- `MULDIV_FAST_SPECIAL_EN` undefined:
  - Every operation takes the full XLEN+3 latency.
  - Special results are produced in FIXUP by override.

## Test plan
- MUL, a=7, b=0xFFFFFFFD (-3) → `result`=0xFFFFFFEB, `done` at cycle 35, `stall_req` high in cycles 0–34 and low in cycle 35.
- MULH, a=b=0x80000000 → 0x40000000. MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV, a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU, a=100, b=7 → 14. REMU on the same → 2.
- Divide by zero: DIVU, a=5, b=0 → 0xFFFFFFFF. REM, a=5, b=0 → 5. Overflow: DIV, a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM on the same → 0.
  - `done` at cycle 2 with `MULDIV_FAST_SPECIAL_EN`, cycle 35 without.
- Flush and reset:
  - DIV started, `flush` at cycle 10 → `busy`=0 at cycle 11, no `done`, `result` retains its prior value.
  - `start` and `flush` together in IDLE → not accepted.
  - `rst_n` low at cycle 20 → all outputs 0 immediately.
- Back-to-back: second `start` at cycle 35 (DONE) is ignored; `start` at cycle 36 is accepted, `done` at cycle 71, operand changes during CALC have no effect.
